// File: rtl/tank_fill_scheduler.sv
// tank_fill_scheduler: round-robin two-tank fill controller sharing one pump.
// Ports: clk, reset (sync, active-low); en scheduler enable; C[i] water present in tank i;
// Pout level-sensor error flags; clr_fault fault acknowledge; pump_on shared pump drive;
// valve one-hot tank valve select; busy in SETTLE/PUMP/COOLDOWN; fault in FAULT;
// fault_code 01 timeout / 10 sensor error; fill_done one-cycle pulse per successful fill.
module tank_fill_scheduler #(
  parameter int SETTLE   = 4,
  parameter int MAX_RUN  = 1000,
  parameter int COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] C,
  input  logic [1:0] Pout,
  input  logic       clr_fault,
  output logic       pump_on,
  output logic [1:0] valve,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       fill_done
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PUMP, S_COOL, S_FAULT} state_t;
  localparam logic [15:0] T_SET  = 16'(SETTLE);
  localparam logic [15:0] T_RUN  = 16'(MAX_RUN - 1);
  localparam logic [15:0] T_COOL = 16'(COOLDOWN - 1);
  state_t      st, nxt;
  logic [15:0] cnt, term;
  logic        g, g_nxt, last, last_nxt, done_nxt;
  logic [1:0]  code_nxt, req;
  assign req = {2{en}} & ~C;
  assign term = st == S_SETTLE ? T_SET : st == S_PUMP ? T_RUN : st == S_COOL ? T_COOL : '0;
  always_comb begin
    nxt = st;
    g_nxt = g;
    last_nxt = last;
    code_nxt = fault_code;
    done_nxt = 1'b0;
    case (st)
      S_IDLE:
        if (|Pout) begin
          nxt = S_FAULT;
          code_nxt = 2'b10;
        end else if (|req) begin
          nxt = S_SETTLE;
          // both tanks asking: serve the one not filled last
          g_nxt = req == 2'b11 ? ~last : req[1];
        end
      S_SETTLE:
        if (|Pout) begin
          nxt = S_FAULT;
          code_nxt = 2'b10;
        end else if (!en) nxt = S_IDLE;
        else if (cnt == T_SET) nxt = S_PUMP;
      S_PUMP:
        if (|Pout) begin
          nxt = S_FAULT;
          code_nxt = 2'b10;
        end else if (C[g]) begin
          nxt = S_COOL;
          done_nxt = 1'b1;
          last_nxt = g;
        end else if (cnt == T_RUN) begin
          nxt = S_FAULT;
          code_nxt = 2'b01;
        end else if (!en) nxt = S_COOL;
      S_COOL:
        if (|Pout) begin
          nxt = S_FAULT;
          code_nxt = 2'b10;
        end else if (cnt == T_COOL) nxt = S_IDLE;
      S_FAULT:
        if (clr_fault && Pout == 2'b00) begin
          nxt = S_IDLE;
          code_nxt = 2'b00;
        end
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they move on the same edge as st
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= S_IDLE;
      cnt <= '0;
      g <= 1'b0;
      last <= 1'b1;
      pump_on <= 1'b0;
      valve <= 2'b00;
      busy <= 1'b0;
      fault <= 1'b0;
      fault_code <= 2'b00;
      fill_done <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? '0 : cnt == term ? cnt : cnt + 16'd1;
      g <= g_nxt;
      last <= last_nxt;
      pump_on <= nxt == S_PUMP;
      valve <= (nxt == S_SETTLE || nxt == S_PUMP) ? {g_nxt, ~g_nxt} : 2'b00;
      busy <= nxt == S_SETTLE || nxt == S_PUMP || nxt == S_COOL;
      fault <= nxt == S_FAULT;
      fault_code <= code_nxt;
      fill_done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_tank_fill_scheduler.sv
// tb_tank_fill_scheduler: vector table plus hand sequences, scoreboard-compared outputs.
module tb_tank_fill_scheduler;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, clr_fault = 1'b0;
  logic [1:0] C = 2'b00, Pout = 2'b00;
  logic pump_on, busy, fault, fill_done;
  logic [1:0] valve, fault_code;
  int total = 0, bad = 0;

  tank_fill_scheduler dut (
    .clk(clk), .reset(reset), .en(en), .C(C), .Pout(Pout), .clr_fault(clr_fault),
    .pump_on(pump_on), .valve(valve), .busy(busy), .fault(fault),
    .fault_code(fault_code), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e; logic [1:0] c; logic [1:0] p; logic clr; logic r;
    logic [7:0] x; string nm;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] sb[$];

  // expected output word: {pump_on, valve, busy, fault, fault_code, fill_done}
  function automatic logic [7:0] o(logic pu, logic [1:0] va, logic bu, logic fa,
                                   logic [1:0] co, logic dn);
    return {pu, va, bu, fa, co, dn};
  endfunction

  function automatic void add(int n, logic e, logic [1:0] c, logic [1:0] p, logic clr,
                              logic r, logic [7:0] x, string nm);
    vec_t v;
    v.e = e; v.c = c; v.p = p; v.clr = clr; v.r = r; v.x = x; v.nm = nm;
    repeat (n) tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic cyc(vec_t v);
    logic [7:0] w;
    en = v.e; C = v.c; Pout = v.p; clr_fault = v.clr; reset = v.r;
    sb.push_back(v.x);
    @(posedge clk); #1;
    w = sb.pop_front();
    chk(v.nm, 16'({pump_on, valve, busy, fault, fault_code, fill_done}), 16'(w));
  endtask

  task automatic tick(logic e, logic [1:0] c, logic [1:0] p, logic clr, logic r);
    en = e; C = c; Pout = p; clr_fault = clr; reset = r;
    @(posedge clk); #1;
  endtask

  localparam logic [7:0] Z = 8'h00;

  initial begin
    vec_t v;
    int n;
    // reset state
    add(2, 0, 2'b00, 2'b00, 0, 0, Z, "reset");
    // basic fill of tank 0
    add(1, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "grant0");
    add(4, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "settle");
    add(3, 1, 2'b10, 2'b00, 0, 1, o(1, 2'b01, 1, 0, 0, 0), "pump");
    add(1, 1, 2'b11, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 1), "fill_done");
    add(7, 1, 2'b11, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "cooldown");
    add(1, 1, 2'b11, 2'b00, 0, 1, Z, "idle");
    // round robin from reset: tank0, tank1, tank0
    add(1, 0, 2'b00, 2'b00, 0, 0, Z, "rr_rst");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "rr_t0");
    add(4, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "rr_settle0");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(1, 2'b01, 1, 0, 0, 0), "rr_pump0");
    add(1, 1, 2'b01, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 1), "rr_done0");
    add(7, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "rr_cool0");
    add(1, 1, 2'b00, 2'b00, 0, 1, Z, "rr_idle0");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b10, 1, 0, 0, 0), "rr_t1");
    add(4, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b10, 1, 0, 0, 0), "rr_settle1");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(1, 2'b10, 1, 0, 0, 0), "rr_pump1");
    add(1, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 1), "rr_done1");
    add(7, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "rr_cool1");
    add(1, 1, 2'b00, 2'b00, 0, 1, Z, "rr_idle1");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "rr_t0b");
    add(4, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "rr_settle2");
    add(2, 1, 2'b00, 2'b00, 0, 1, o(1, 2'b01, 1, 0, 0, 0), "rr_pump2");
    // sensor error together with water arriving: fault wins, no fill_done
    add(1, 1, 2'b01, 2'b01, 0, 1, o(0, 2'b00, 0, 1, 2'b10, 0), "sens_fault");
    add(2, 1, 2'b01, 2'b01, 1, 1, o(0, 2'b00, 0, 1, 2'b10, 0), "clr_ignored");
    add(1, 0, 2'b00, 2'b00, 1, 1, Z, "clr_ok");
    add(1, 0, 2'b00, 2'b00, 0, 1, Z, "idle_after_clr");
    // sensor error from IDLE
    add(1, 0, 2'b00, 2'b10, 0, 1, o(0, 2'b00, 0, 1, 2'b10, 0), "idle_fault");
    add(1, 0, 2'b00, 2'b00, 1, 1, Z, "clr_idle_fault");
    // enable drop in SETTLE
    add(1, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "sd_grant");
    add(2, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "sd_settle");
    add(1, 0, 2'b10, 2'b00, 0, 1, Z, "settle_drop");
    add(1, 0, 2'b10, 2'b00, 0, 1, Z, "sd_idle");
    // enable drop in PUMP
    add(1, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "pd_grant");
    add(4, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "pd_settle");
    add(2, 1, 2'b10, 2'b00, 0, 1, o(1, 2'b01, 1, 0, 0, 0), "pd_pump");
    add(1, 0, 2'b10, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "pump_drop");
    add(7, 0, 2'b10, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "pd_cool");
    add(1, 0, 2'b10, 2'b00, 0, 1, Z, "pd_idle");
    // fill tank 0 so the next tie goes to tank 1, then reset mid-PUMP
    add(1, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "f0_grant");
    add(4, 1, 2'b10, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "f0_settle");
    add(1, 1, 2'b10, 2'b00, 0, 1, o(1, 2'b01, 1, 0, 0, 0), "f0_pump");
    add(1, 1, 2'b01, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 1), "f0_done");
    add(7, 0, 2'b11, 2'b00, 0, 1, o(0, 2'b00, 1, 0, 0, 0), "f0_cool");
    add(1, 0, 2'b11, 2'b00, 0, 1, Z, "f0_idle");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b10, 1, 0, 0, 0), "tie_t1");
    add(4, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b10, 1, 0, 0, 0), "tie_settle");
    add(2, 1, 2'b00, 2'b00, 0, 1, o(1, 2'b10, 1, 0, 0, 0), "tie_pump");
    add(1, 1, 2'b00, 2'b00, 0, 0, Z, "rst_pump");
    add(1, 1, 2'b00, 2'b00, 0, 1, o(0, 2'b01, 1, 0, 0, 0), "post_rst_t0");

    foreach (tbl[i]) cyc(tbl[i]);

    // timeout: C[0] never rises, count PUMP cycles until FAULT (bounded)
    tick(0, 2'b10, 2'b00, 0, 0);
    n = 0;
    for (int k = 0; k < 1200 && !fault; k++) begin
      tick(1, 2'b10, 2'b00, 0, 1);
      if (pump_on) n++;
    end
    chk("timeout_fault", 16'(fault), 16'd1);
    chk("timeout_cycles", 16'(n), 16'd1000);
    chk("timeout_code", 16'(fault_code), 16'h1);
    tick(1, 2'b10, 2'b00, 0, 1);
    chk("fault_held", 16'({fault, fault_code}), 16'h5);
    v.e = 1; v.c = 2'b10; v.p = 2'b00; v.clr = 1; v.r = 1; v.x = Z; v.nm = "to_clr";
    cyc(v);
    v.clr = 0; v.x = o(0, 2'b01, 1, 0, 0, 0); v.nm = "to_regrant";
    cyc(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
